// File: rtl/ne_fp_e_align_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ne_fp_align_pkg
// Description : Mode bit indices, default constants and shift saturation
//               helper shared by the exponent-align pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package ne_fp_align_pkg;

    localparam int MODE_FP4  = 3;
    localparam int MODE_FP16 = 2;
    localparam int MODE_FP8  = 1;
    localparam int MODE_TF32 = 0;

    localparam int DEF_BIAS     = -28;
    localparam int DEF_FP4_EMAX = 'h02D;
    localparam int DEF_THR_FP8  = 25;
    localparam int DEF_THR_FP16 = 26;

    // Negative differences clamp to zero, large ones to the all-ones shift.
    function automatic int unsigned sat_shift(input int diff, input int sw);
        int unsigned lim;
        lim = (32'd1 << sw) - 32'd1;
        if (diff <= 0)
            return 0;
        else if (int'(lim) < diff)
            return lim;
        else
            return int'(diff);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ne_fp_e_align_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface   : ne_fp_e_align_pipe_if
// Description : Input beat and result handshake bundle of the align pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface ne_fp_e_align_pipe_if #(
    parameter int LANES = 16,
    parameter int EW    = 9,
    parameter int BW    = 6,
    parameter int SW    = 6
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [3:0]            op_mode;
    logic [LANES*EW-1:0]   a_e;
    logic [LANES*BW-1:0]   b_e;
    logic [LANES-1:0]      lane_msk;
    logic                  out_vld;
    logic                  out_rdy;
    logic [3:0]            out_mode;
    logic [EW-1:0]         e_max;
    logic [LANES*SW-1:0]   a_e_sub;
    logic [LANES*SW-1:0]   b_e_sub;
    logic [LANES-1:0]      a_e_ovf;
    logic [LANES-1:0]      b_e_ovf;

    modport master (
        output in_vld, op_mode, a_e, b_e, lane_msk, out_rdy,
        input  in_rdy, out_vld, out_mode, e_max, a_e_sub, b_e_sub, a_e_ovf, b_e_ovf
    );

    modport slave (
        input  in_vld, op_mode, a_e, b_e, lane_msk, out_rdy,
        output in_rdy, out_vld, out_mode, e_max, a_e_sub, b_e_sub, a_e_ovf, b_e_ovf
    );
endinterface
`default_nettype wire

// File: rtl/ne_fp_smax_tree.sv
`default_nettype none
// ============================================================================
// Module      : ne_fp_smax_tree
// Description : Combinational signed maximum over N masked W-bit inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ne_fp_smax_tree #(
    parameter int N = 4,
    parameter int W = 9
) (
    input  wire logic [N*W-1:0]    din,
    input  wire logic [N-1:0]      msk,
    output logic signed [W-1:0]    dmax
);
    // Excluded inputs fall back to the most negative code, the identity for max.
    localparam logic signed [W-1:0] c_most_neg = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        dmax = c_most_neg;
        for (int i = 0; i < N; i++) begin
            if (msk[i] && ($signed(din[i*W +: W]) > dmax))
                dmax = din[i*W +: W];
        end
    end
endmodule
`default_nettype wire

// File: rtl/ne_fp_e_align_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ne_fp_e_align_pipe
// Description : Three-stage handshaked block-max exponent and per-lane
//               saturated shift / shifted-out flag generator.
// Revision    : 1.0 - initial release
// ============================================================================
module ne_fp_e_align_pipe
    import ne_fp_align_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int GRP      = 4,
    parameter int EW       = 9,
    parameter int BW       = 6,
    parameter int SW       = 6,
    parameter int BIAS     = DEF_BIAS,
    parameter int FP4_EMAX = DEF_FP4_EMAX,
    parameter int THR_FP8  = DEF_THR_FP8,
    parameter int THR_FP16 = DEF_THR_FP16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    ne_fp_e_align_pipe_if.slave     bus
);
    localparam int NG = LANES / GRP;
    localparam int NF = 2 * NG + 1;
    localparam logic [EW-1:0] c_bias     = EW'(BIAS);
    localparam logic [EW-1:0] c_fp4_emax = EW'(FP4_EMAX);

    // ---------------- flow control (bubble collapse) ----------------
    logic r1_vld, r2_vld, r3_vld;
    logic w_ld1, w_ld2, w_ld3;

    assign w_ld3      = !r3_vld || bus.out_rdy;
    assign w_ld2      = !r2_vld || w_ld3;
    assign w_ld1      = !r1_vld || w_ld2;
    assign bus.in_rdy = w_ld1;

    // ---------------- S1: group maxima ----------------
    logic [LANES*EW-1:0] w_b_ext;
    logic [NG*EW-1:0]    w_ga_max, w_gb_max;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_bext
            logic signed [BW-1:0] w_b;
            assign w_b                 = bus.b_e[l*BW +: BW];
            assign w_b_ext[l*EW +: EW] = EW'(w_b);
        end
        for (genvar g = 0; g < NG; g++) begin : g_grp
            ne_fp_smax_tree #(.N(GRP), .W(EW)) u_amax (
                .din  (bus.a_e[g*GRP*EW +: GRP*EW]),
                .msk  (bus.lane_msk[g*GRP +: GRP]),
                .dmax (w_ga_max[g*EW +: EW])
            );
            ne_fp_smax_tree #(.N(GRP), .W(EW)) u_bmax (
                .din  (w_b_ext[g*GRP*EW +: GRP*EW]),
                .msk  (bus.lane_msk[g*GRP +: GRP]),
                .dmax (w_gb_max[g*EW +: EW])
            );
        end
    endgenerate

    logic [3:0]          r1_mode;
    logic [LANES*EW-1:0] r1_a_e;
    logic [LANES*BW-1:0] r1_b_e;
    logic [LANES-1:0]    r1_msk;
    logic [NG*EW-1:0]    r1_ga_max, r1_gb_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld    <= 1'b0;
            r1_mode   <= '0;
            r1_a_e    <= '0;
            r1_b_e    <= '0;
            r1_msk    <= '0;
            r1_ga_max <= '0;
            r1_gb_max <= '0;
        end else if (w_ld1) begin
            r1_vld <= bus.in_vld;
            if (bus.in_vld) begin
                r1_mode   <= bus.op_mode;
                r1_a_e    <= bus.a_e;
                r1_b_e    <= bus.b_e;
                r1_msk    <= bus.lane_msk;
                r1_ga_max <= w_ga_max;
                r1_gb_max <= w_gb_max;
            end
        end
    end

    // ---------------- S2: final max and mode select ----------------
    logic signed [EW-1:0] w_fin_max;
    logic [EW-1:0]        w_e_max_s2;

    // b group maxima only take part when FP8 is the effective mode.
    ne_fp_smax_tree #(.N(NF), .W(EW)) u_fmax (
        .din  ({c_bias, r1_gb_max, r1_ga_max}),
        .msk  ({1'b1, {NG{r1_mode[MODE_FP8] & !r1_mode[MODE_FP4]}}, {NG{1'b1}}}),
        .dmax (w_fin_max)
    );

    always_comb begin
        w_e_max_s2 = '0;
        if (r1_mode[MODE_FP4])
            w_e_max_s2 = c_fp4_emax;
        else if (r1_mode[MODE_FP8] || r1_mode[MODE_FP16])
            w_e_max_s2 = w_fin_max;
    end

    logic [3:0]          r2_mode;
    logic [LANES*EW-1:0] r2_a_e;
    logic [LANES*BW-1:0] r2_b_e;
    logic [LANES-1:0]    r2_msk;
    logic [EW-1:0]       r2_e_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_vld   <= 1'b0;
            r2_mode  <= '0;
            r2_a_e   <= '0;
            r2_b_e   <= '0;
            r2_msk   <= '0;
            r2_e_max <= '0;
        end else if (w_ld2) begin
            r2_vld <= r1_vld;
            if (r1_vld) begin
                r2_mode  <= r1_mode;
                r2_a_e   <= r1_a_e;
                r2_b_e   <= r1_b_e;
                r2_msk   <= r1_msk;
                r2_e_max <= w_e_max_s2;
            end
        end
    end

    // ---------------- S3: subtract, saturate, flag ----------------
    logic w_fp4, w_fp8, w_fp16;
    logic [LANES*SW-1:0] w_a_sub, w_b_sub;
    logic [LANES-1:0]    w_a_ovf, w_b_ovf;

    assign w_fp4  = r2_mode[MODE_FP4];
    assign w_fp8  = !w_fp4 && r2_mode[MODE_FP8];
    assign w_fp16 = !w_fp4 && !r2_mode[MODE_FP8] && r2_mode[MODE_FP16];

    always_comb begin
        logic signed [EW-1:0] v_em;
        logic signed [EW-1:0] v_ea;
        logic signed [BW-1:0] v_eb;
        logic signed [EW:0]   v_diff_a;
        logic signed [EW:0]   v_diff_b;
        int unsigned          v_sat_a;
        int unsigned          v_sat_b;
        v_em     = r2_e_max;
        v_ea     = '0;
        v_eb     = '0;
        v_diff_a = '0;
        v_diff_b = '0;
        v_sat_a  = 0;
        v_sat_b  = 0;
        w_a_sub  = '0;
        w_b_sub  = '0;
        w_a_ovf  = '0;
        w_b_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            v_ea     = r2_a_e[i*EW +: EW];
            v_eb     = r2_b_e[i*BW +: BW];
            v_diff_a = {v_em[EW-1], v_em} - {v_ea[EW-1], v_ea};
            v_diff_b = {v_em[EW-1], v_em} - {{(EW+1-BW){v_eb[BW-1]}}, v_eb};
            v_sat_a  = sat_shift(int'(v_diff_a), SW);
            v_sat_b  = sat_shift(int'(v_diff_b), SW);
            if (r2_msk[i]) begin
                if (w_fp4 || w_fp8 || w_fp16)
                    w_a_sub[i*SW +: SW] = v_sat_a[SW-1:0];
                w_a_ovf[i] = (w_fp8  && (int'(v_diff_a) >= THR_FP8)) ||
                             (w_fp16 && (int'(v_diff_a) >= THR_FP16));
                if (w_fp4 || w_fp8)
                    w_b_sub[i*SW +: SW] = v_sat_b[SW-1:0];
                w_b_ovf[i] = w_fp8 && (int'(v_diff_b) >= THR_FP8);
            end else begin
                w_a_ovf[i] = w_fp8 || w_fp16;
                w_b_ovf[i] = w_fp8;
            end
        end
    end

    logic [3:0]          r3_mode;
    logic [EW-1:0]       r3_e_max;
    logic [LANES*SW-1:0] r3_a_sub, r3_b_sub;
    logic [LANES-1:0]    r3_a_ovf, r3_b_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_vld   <= 1'b0;
            r3_mode  <= '0;
            r3_e_max <= '0;
            r3_a_sub <= '0;
            r3_b_sub <= '0;
            r3_a_ovf <= '0;
            r3_b_ovf <= '0;
        end else if (w_ld3) begin
            r3_vld <= r2_vld;
            if (r2_vld) begin
                r3_mode  <= r2_mode;
                r3_e_max <= r2_e_max;
                r3_a_sub <= w_a_sub;
                r3_b_sub <= w_b_sub;
                r3_a_ovf <= w_a_ovf;
                r3_b_ovf <= w_b_ovf;
            end
        end
    end

    assign bus.out_vld  = r3_vld;
    assign bus.out_mode = r3_mode;
    assign bus.e_max    = r3_e_max;
    assign bus.a_e_sub  = r3_a_sub;
    assign bus.b_e_sub  = r3_b_sub;
    assign bus.a_e_ovf  = r3_a_ovf;
    assign bus.b_e_ovf  = r3_b_ovf;
endmodule
`default_nettype wire

// File: tb/tb_ne_fp_e_align_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ne_fp_e_align_pipe
// Description : Directed self-checking bench for the exponent-align pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ne_fp_e_align_pipe;
    localparam int LANES = 16;
    localparam int EW    = 9;
    localparam int BW    = 6;
    localparam int SW    = 6;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ne_fp_e_align_pipe_if #(.LANES(LANES), .EW(EW), .BW(BW), .SW(SW)) bus ();

    ne_fp_e_align_pipe #(
        .LANES(LANES), .GRP(4), .EW(EW), .BW(BW), .SW(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic int a_sub(input int i);
        return int'(bus.a_e_sub[i*SW +: SW]);
    endfunction

    function automatic int b_sub(input int i);
        return int'(bus.b_e_sub[i*SW +: SW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input int v);
        bus.a_e[i*EW +: EW] = v[EW-1:0];
    endtask

    task automatic set_b(input int i, input int v);
        bus.b_e[i*BW +: BW] = v[BW-1:0];
    endtask

    task automatic load_beat(input logic [3:0] mode, input int av, input int bv);
        bus.op_mode  = mode;
        bus.lane_msk = '1;
        for (int i = 0; i < LANES; i++) begin
            set_a(i, av);
            set_b(i, bv);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_vld   = 1'b0;
        bus.out_rdy  = 1'b1;
        bus.op_mode  = '0;
        bus.a_e      = '0;
        bus.b_e      = '0;
        bus.lane_msk = '0;
        repeat (3) tick();
        checks++;
        if (bus.out_vld !== 1'b0 || bus.e_max !== '0 || bus.out_mode !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: out_vld=%b e_max=%h mode=%h required 0/0/0",
                     bus.out_vld, bus.e_max, bus.out_mode);
        end
        checks++;
        if (bus.a_e_sub !== '0 || bus.b_e_sub !== '0 || bus.a_e_ovf !== '0 || bus.b_e_ovf !== '0) begin
            errors++;
            $display("FAIL reset_data: a_sub=%h b_sub=%h a_ovf=%h b_ovf=%h required 0",
                     bus.a_e_sub, bus.b_e_sub, bus.a_e_ovf, bus.b_e_ovf);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy: got %b required 1", bus.in_rdy);
        end
    endtask

    task automatic test_fp8_basic();
        load_beat(4'b0010, -3, 0);
        set_a(5, 10);
        set_b(2, 12);
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL fp8_latency1: out_vld got %b required 0", bus.out_vld);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL fp8_latency2: out_vld got %b required 0", bus.out_vld);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b1) begin
            errors++;
            $display("FAIL fp8_latency3: out_vld got %b required 1", bus.out_vld);
        end
        checks++;
        if (bus.e_max !== 9'd12 || bus.out_mode !== 4'b0010) begin
            errors++;
            $display("FAIL fp8_emax: e_max=%h mode=%h required 00c/2", bus.e_max, bus.out_mode);
        end
        for (int i = 0; i < LANES; i++) begin
            int ea;
            int eb;
            ea = (i == 5) ? 2 : 15;
            eb = (i == 2) ? 0 : 12;
            checks++;
            if (a_sub(i) != ea || b_sub(i) != eb) begin
                errors++;
                $display("FAIL fp8_sub lane %0d: a=%0d b=%0d required a=%0d b=%0d",
                         i, a_sub(i), b_sub(i), ea, eb);
            end
        end
        checks++;
        if (bus.a_e_ovf !== 16'h0000 || bus.b_e_ovf !== 16'h0000) begin
            errors++;
            $display("FAIL fp8_ovf: a=%h b=%h required 0000/0000", bus.a_e_ovf, bus.b_e_ovf);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL fp8_drain: out_vld got %b required 0", bus.out_vld);
        end
    endtask

    task automatic test_fp16_sat();
        load_beat(4'b0100, 0, 31);
        set_a(0, 100);
        set_a(1, -200);
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.e_max !== 9'd100 || bus.out_mode !== 4'b0100) begin
            errors++;
            $display("FAIL fp16_emax: vld=%b e_max=%h mode=%h required 1/064/4",
                     bus.out_vld, bus.e_max, bus.out_mode);
        end
        for (int i = 0; i < LANES; i++) begin
            int ea;
            ea = (i == 0) ? 0 : 63;
            checks++;
            if (a_sub(i) != ea) begin
                errors++;
                $display("FAIL fp16_a_sub lane %0d: got %0d required %0d", i, a_sub(i), ea);
            end
        end
        checks++;
        if (bus.a_e_ovf !== 16'hFFFE) begin
            errors++;
            $display("FAIL fp16_a_ovf: got %h required fffe", bus.a_e_ovf);
        end
        checks++;
        if (bus.b_e_sub !== '0 || bus.b_e_ovf !== 16'h0000) begin
            errors++;
            $display("FAIL fp16_b_gated: b_sub=%h b_ovf=%h required 0", bus.b_e_sub, bus.b_e_ovf);
        end
        tick();
    endtask

    task automatic test_fp8_mask();
        load_beat(4'b0010, 50, 20);
        bus.lane_msk = 16'h0001;
        set_a(0, -30);
        set_b(0, -30);
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.e_max !== 9'h1E4) begin
            errors++;
            $display("FAIL mask_emax: vld=%b e_max=%h required 1/1e4", bus.out_vld, bus.e_max);
        end
        for (int i = 0; i < LANES; i++) begin
            int es;
            es = (i == 0) ? 2 : 0;
            checks++;
            if (a_sub(i) != es || b_sub(i) != es) begin
                errors++;
                $display("FAIL mask_sub lane %0d: a=%0d b=%0d required %0d",
                         i, a_sub(i), b_sub(i), es);
            end
        end
        checks++;
        if (bus.a_e_ovf !== 16'hFFFE || bus.b_e_ovf !== 16'hFFFE) begin
            errors++;
            $display("FAIL mask_ovf: a=%h b=%h required fffe/fffe", bus.a_e_ovf, bus.b_e_ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        load_beat(4'b1000, 0, 0);
        for (int i = 0; i < LANES; i++) begin
            set_a(i, (i == 0) ? 100 : i);
            set_b(i, -i);
        end
        bus.in_vld = 1'b1;
        tick();
        load_beat(4'b0001, 7, 3);
        #1;
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_rdy: got %b required 1", bus.in_rdy);
        end
        tick();
        bus.in_vld = 1'b0;
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.e_max !== 9'h02D || bus.out_mode !== 4'b1000) begin
            errors++;
            $display("FAIL fp4_emax: vld=%b e_max=%h mode=%h required 1/02d/8",
                     bus.out_vld, bus.e_max, bus.out_mode);
        end
        for (int i = 0; i < LANES; i++) begin
            int ea;
            int eb;
            ea = (i == 0) ? 0 : 45 - i;
            eb = 45 + i;
            checks++;
            if (a_sub(i) != ea || b_sub(i) != eb) begin
                errors++;
                $display("FAIL fp4_sub lane %0d: a=%0d b=%0d required a=%0d b=%0d",
                         i, a_sub(i), b_sub(i), ea, eb);
            end
        end
        checks++;
        if (bus.a_e_ovf !== 16'h0000 || bus.b_e_ovf !== 16'h0000) begin
            errors++;
            $display("FAIL fp4_ovf: a=%h b=%h required 0", bus.a_e_ovf, bus.b_e_ovf);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.e_max !== 9'h000 || bus.out_mode !== 4'b0001) begin
            errors++;
            $display("FAIL tf32_emax: vld=%b e_max=%h mode=%h required 1/000/1",
                     bus.out_vld, bus.e_max, bus.out_mode);
        end
        checks++;
        if (bus.a_e_sub !== '0 || bus.b_e_sub !== '0 || bus.a_e_ovf !== '0 || bus.b_e_ovf !== '0) begin
            errors++;
            $display("FAIL tf32_zero: a_sub=%h b_sub=%h a_ovf=%h b_ovf=%h required 0",
                     bus.a_e_sub, bus.b_e_sub, bus.a_e_ovf, bus.b_e_ovf);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int nxt;
        int got;
        logic acc;
        int em_q [5];
        int bs_q [5];
        nxt = 0;
        got = 0;
        for (int k = 0; k < 5; k++) begin
            em_q[k] = 0;
            bs_q[k] = 0;
        end
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            load_beat(4'b0010, nxt + 1, 0);
            bus.in_vld = 1'b1;
            #1;
            acc = bus.in_vld & bus.in_rdy;
            if (bus.out_vld) begin
                checks++;
                if (bus.e_max !== 9'd1 || b_sub(0) != 1) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: e_max=%h b_sub0=%0d required 001/1",
                             c, bus.e_max, b_sub(0));
                end
            end
            tick();
            if (acc) nxt++;
        end
        checks++;
        if (nxt != 3 || bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: accepted=%0d in_rdy=%b required 3/0", nxt, bus.in_rdy);
        end
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (nxt < 5) begin
                load_beat(4'b0010, nxt + 1, 0);
                bus.in_vld = 1'b1;
            end else begin
                bus.in_vld = 1'b0;
            end
            #1;
            acc = bus.in_vld & bus.in_rdy;
            if (bus.out_vld) begin
                em_q[got] = int'(bus.e_max);
                bs_q[got] = b_sub(0);
                got++;
            end
            tick();
            if (acc) nxt++;
        end
        bus.in_vld = 1'b0;
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL drain_count: got %0d beats required 5", got);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (em_q[k] != k + 1 || bs_q[k] != k + 1) begin
                errors++;
                $display("FAIL drain_order beat %0d: e_max=%0d b_sub0=%0d required %0d",
                         k, em_q[k], bs_q[k], k + 1);
            end
        end
        repeat (3) begin
            checks++;
            if (bus.out_vld !== 1'b0) begin
                errors++;
                $display("FAIL drain_extra: out_vld got %b required 0", bus.out_vld);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        bus.out_rdy = 1'b1;
        load_beat(4'b0010, 5, 0);
        bus.in_vld = 1'b1;
        tick();
        load_beat(4'b0010, 6, 0);
        tick();
        bus.in_vld = 1'b0;
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.e_max !== 9'd5) begin
            errors++;
            $display("FAIL rst_pre: vld=%b e_max=%h required 1/005", bus.out_vld, bus.e_max);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.e_max !== '0 || bus.out_mode !== '0 ||
            bus.a_e_sub !== '0 || bus.b_e_sub !== '0 || bus.a_e_ovf !== '0 || bus.b_e_ovf !== '0) begin
            errors++;
            $display("FAIL rst_async: vld=%b e_max=%h b_sub=%h a_ovf=%h required all 0",
                     bus.out_vld, bus.e_max, bus.b_e_sub, bus.a_e_ovf);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.out_vld !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale cycle %0d: out_vld got %b required 0", c, bus.out_vld);
            end
            tick();
        end
        load_beat(4'b0010, 7, 0);
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_relat2: out_vld got %b required 0", bus.out_vld);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.e_max !== 9'd7) begin
            errors++;
            $display("FAIL rst_relat3: vld=%b e_max=%h required 1/007", bus.out_vld, bus.e_max);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fp8_basic();
        test_fp16_sat();
        test_fp8_mask();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
